digital_lock_lockout: RTL and testbench

Parametrised successor to the four-key state-machine digital lock. It adds configurable key count, configurable code length, failed-attempt counting and a timed lockout after repeated wrong codes. It sits between the debounced pushbutton bank and the lock actuator/status LEDs. The code is programmed while unlocked and checked while locked.

---
 rtl/digital_lock_pkg.sv | 29 ++
 rtl/key_press_detect.sv | 38 +++
 rtl/digital_lock_lockout.sv | 229 ++++++++++++++++++++++
 tb/tb_digital_lock_lockout.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/digital_lock_pkg.sv
// Shared state encodings and width helpers for the parametrised digital lock.
package digital_lock_pkg;

  typedef enum logic [2:0] {
    UNLOCKED_IDLE  = 3'd0,
    UNLOCKED_ENTER = 3'd1,
    LOCKED_IDLE    = 3'd2,
    LOCKED_ENTER   = 3'd3,
    LOCKOUT        = 3'd4
  } lock_state_t;

  localparam int STATE_W = 3;

  // Width of a key index; never narrower than one bit.
  function automatic int key_width(input int keys);
    return (keys < 2) ? 1 : $clog2(keys);
  endfunction

  // Width of a counter that must be able to hold max_value itself.
  function automatic int count_width(input int max_value);
    return (max_value < 1) ? 1 : $clog2(max_value + 1);
  endfunction

  // Width of a down/up timer spanning 0..cycles-1.
  function automatic int timer_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/key_press_detect.sv
// Turns the debounced key bank into single press events with the key index.
module key_press_detect
  import digital_lock_pkg::*;
#(
  parameter int KEYS = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [KEYS-1:0]               key,
  output logic                          press_valid,
  output logic [key_width(KEYS)-1:0]    key_index
);

  localparam int KW = key_width(KEYS);

  logic [KEYS-1:0] key_q;

  // All-ones after reset so a key held through reset must be released first.
  always_ff @(posedge clock) begin
    if (reset) begin
      key_q <= '1;
    end else begin
      key_q <= key;
    end
  end

  always_comb begin
    key_index = '0;
    for (int i = 0; i < KEYS; i++) begin
      if (key[i]) begin
        key_index = KW'(i);
      end
    end
  end

  assign press_valid = $onehot(key) && (key_q == '0);

endmodule

// File: rtl/digital_lock_lockout.sv
// Code-programmable lock with failed-attempt counting and timed lockout.
// Optional macro ENTRY_TIMEOUT_EN abandons an idle partial entry after TIMEOUT_CYCLES.
module digital_lock_lockout
  import digital_lock_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int KEYS           = 4,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int LOCKOUT_CYCLES = 100,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [KEYS-1:0]                      key,
  output logic                                 locked,
  output logic                                 lockout,
  output logic                                 unlock_pulse,
  output logic                                 fail_pulse,
  output logic [STATE_W-1:0]                   state,
  output logic [count_width(DIGITS)-1:0]       digit_count,
  output logic [count_width(MAX_ATTEMPTS)-1:0] fail_count
);

  localparam int KW = key_width(KEYS);
  localparam int CW = count_width(DIGITS);
  localparam int FW = count_width(MAX_ATTEMPTS);
  localparam int TW = timer_width(LOCKOUT_CYCLES);

  localparam logic [CW-1:0] LAST_DIGIT   = CW'(DIGITS - 1);
  localparam logic [FW-1:0] LAST_ATTEMPT = FW'(MAX_ATTEMPTS - 1);
  localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);

  logic          press_valid;
  logic [KW-1:0] press_digit;

  lock_state_t   state_q, state_d;
  logic [CW-1:0] digit_count_q, digit_count_d;
  logic [FW-1:0] fail_count_q, fail_count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          mismatch_q, mismatch_d;
  logic          unlock_q, unlock_d;
  logic          fail_q, fail_d;

  logic          entry_we;
  logic          code_commit;
  logic          timeout_hit;
  logic          last_digit;
  logic          digit_wrong;
  logic [KW-1:0] expected_digit;

  logic [KW-1:0] code_q  [DIGITS];
  logic [KW-1:0] entry_q [DIGITS];

  key_press_detect #(
    .KEYS (KEYS)
  ) u_press (
    .clock       (clock),
    .reset       (reset),
    .key         (key),
    .press_valid (press_valid),
    .key_index   (press_digit)
  );

`ifdef ENTRY_TIMEOUT_EN
  localparam int IW = timer_width(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT_CYCLES - 1);

  logic [IW-1:0] idle_q;
  logic          in_entry;

  assign in_entry = (state_q == UNLOCKED_ENTER) || (state_q == LOCKED_ENTER);

  always_ff @(posedge clock) begin
    if (reset || press_valid || !in_entry) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_q + IW'(1);
    end
  end

  assign timeout_hit = in_entry && !press_valid && (idle_q == IDLE_LIMIT);
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    expected_digit = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_count_q == CW'(i)) begin
        expected_digit = code_q[i];
      end
    end
  end

  assign last_digit  = (digit_count_q == LAST_DIGIT);
  assign digit_wrong = (press_digit != expected_digit);

  // The final press both completes the entry and takes the decision on the same edge.
  always_comb begin
    state_d       = state_q;
    digit_count_d = digit_count_q;
    fail_count_d  = fail_count_q;
    timer_d       = timer_q;
    mismatch_d    = mismatch_q;
    unlock_d      = 1'b0;
    fail_d        = 1'b0;
    entry_we      = 1'b0;
    code_commit   = 1'b0;

    case (state_q)
      UNLOCKED_IDLE, UNLOCKED_ENTER: begin
        if (press_valid) begin
          entry_we = 1'b1;
          if (last_digit) begin
            code_commit   = 1'b1;
            state_d       = LOCKED_IDLE;
            digit_count_d = '0;
          end else begin
            state_d       = UNLOCKED_ENTER;
            digit_count_d = digit_count_q + CW'(1);
          end
        end else if (timeout_hit) begin
          state_d       = UNLOCKED_IDLE;
          digit_count_d = '0;
        end
      end

      LOCKED_IDLE, LOCKED_ENTER: begin
        if (press_valid) begin
          if (last_digit) begin
            digit_count_d = '0;
            mismatch_d    = 1'b0;
            if (!(mismatch_q || digit_wrong)) begin
              state_d      = UNLOCKED_IDLE;
              unlock_d     = 1'b1;
              fail_count_d = '0;
            end else if (fail_count_q == LAST_ATTEMPT) begin
              state_d      = LOCKOUT;
              fail_d       = 1'b1;
              fail_count_d = fail_count_q + FW'(1);
              timer_d      = LOCKOUT_LOAD;
            end else begin
              state_d      = LOCKED_IDLE;
              fail_d       = 1'b1;
              fail_count_d = fail_count_q + FW'(1);
            end
          end else begin
            state_d       = LOCKED_ENTER;
            digit_count_d = digit_count_q + CW'(1);
            mismatch_d    = mismatch_q || digit_wrong;
          end
        end else if (timeout_hit) begin
          state_d       = LOCKED_IDLE;
          digit_count_d = '0;
          mismatch_d    = 1'b0;
        end
      end

      LOCKOUT: begin
        if (timer_q == '0) begin
          state_d      = LOCKED_IDLE;
          fail_count_d = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      default: begin
        state_d       = UNLOCKED_IDLE;
        digit_count_d = '0;
        mismatch_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= UNLOCKED_IDLE;
      digit_count_q <= '0;
      fail_count_q  <= '0;
      timer_q       <= '0;
      mismatch_q    <= 1'b0;
      unlock_q      <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      digit_count_q <= digit_count_d;
      fail_count_q  <= fail_count_d;
      timer_q       <= timer_d;
      mismatch_q    <= mismatch_d;
      unlock_q      <= unlock_d;
      fail_q        <= fail_d;
    end
  end

  // Partial entries live in a shadow buffer so an abandoned entry never touches the code.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DIGITS; i++) begin
        code_q[i]  <= '0;
        entry_q[i] <= '0;
      end
    end else begin
      if (entry_we) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (digit_count_q == CW'(i)) begin
            entry_q[i] <= press_digit;
          end
        end
      end
      if (code_commit) begin
        for (int i = 0; i < DIGITS; i++) begin
          code_q[i] <= (i == DIGITS - 1) ? press_digit : entry_q[i];
        end
      end
    end
  end

  assign state        = state_q;
  assign locked       = (state_q != UNLOCKED_IDLE) && (state_q != UNLOCKED_ENTER);
  assign lockout      = (state_q == LOCKOUT);
  assign unlock_pulse = unlock_q;
  assign fail_pulse   = fail_q;
  assign digit_count  = digit_count_q;
  assign fail_count   = fail_count_q;

endmodule

// File: tb/tb_digital_lock_lockout.sv
// Self-checking bench for digital_lock_lockout: behavioural model plus directed vectors.
module tb_digital_lock_lockout;

  localparam int DIGITS   = 4;
  localparam int KEYS     = 4;
  localparam int MAX_ATT  = 3;
  localparam int LOCK_CYC = 16;
  localparam int TMO_CYC  = 20;
`ifdef ENTRY_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic            clock;
  logic            reset;
  logic [KEYS-1:0] key;
  logic            locked, lockout, unlock_pulse, fail_pulse;
  logic [2:0]      state;
  logic [2:0]      digit_count;
  logic [1:0]      fail_count;

  int n_checks = 0;
  int n_fail   = 0;

  digital_lock_lockout #(
    .DIGITS         (DIGITS),
    .KEYS           (KEYS),
    .MAX_ATTEMPTS   (MAX_ATT),
    .LOCKOUT_CYCLES (LOCK_CYC),
    .TIMEOUT_CYCLES (TMO_CYC)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .key          (key),
    .locked       (locked),
    .lockout      (lockout),
    .unlock_pulse (unlock_pulse),
    .fail_pulse   (fail_pulse),
    .state        (state),
    .digit_count  (digit_count),
    .fail_count   (fail_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string name, input int actual, input int required);
    n_checks++;
    if (actual != required) begin
      n_fail++;
      $display("[TB] FAIL %s: actual %0d required %0d at %0t", name, actual, required, $time);
    end
  endtask

  // Model: a lock is either open or closed, may be serving a lockout, and holds
  // the digits typed so far as a list.
  logic [KEYS-1:0] s_key;
  logic            s_reset;
  logic [KEYS-1:0] m_prev;
  int              m_entry[$];
  int              m_code[DIGITS];
  bit              m_locked;
  int              m_lock_left;
  int              m_fails;
  int              m_idle;
  bit              m_unlock, m_fail;

  always @(posedge clock) begin
    s_key   <= key;
    s_reset <= reset;
  end

  task automatic model_step();
    bit press;
    bit wrong;
    int d;
    m_unlock = 1'b0;
    m_fail   = 1'b0;
    if (s_reset) begin
      m_prev      = '1;
      m_entry.delete();
      for (int i = 0; i < DIGITS; i++) m_code[i] = 0;
      m_locked    = 1'b0;
      m_lock_left = 0;
      m_fails     = 0;
      m_idle      = 0;
    end else begin
      press = ($countones(s_key) == 1) && (m_prev == '0);
      d = 0;
      for (int i = 0; i < KEYS; i++) if (s_key[i]) d = i;
      m_prev = s_key;
      if (m_lock_left > 0) begin
        m_lock_left--;
        if (m_lock_left == 0) m_fails = 0;
      end else if (press) begin
        m_idle = 0;
        m_entry.push_back(d);
        if (m_entry.size() == DIGITS) begin
          if (!m_locked) begin
            for (int i = 0; i < DIGITS; i++) m_code[i] = m_entry[i];
            m_locked = 1'b1;
          end else begin
            wrong = 1'b0;
            for (int i = 0; i < DIGITS; i++) if (m_entry[i] != m_code[i]) wrong = 1'b1;
            if (!wrong) begin
              m_locked = 1'b0;
              m_unlock = 1'b1;
              m_fails  = 0;
            end else begin
              m_fail = 1'b1;
              m_fails++;
              if (m_fails == MAX_ATT) m_lock_left = LOCK_CYC;
            end
          end
          m_entry.delete();
        end
      end else if (TIMEOUT_ON && m_entry.size() > 0) begin
        m_idle++;
        if (m_idle == TMO_CYC) begin
          m_entry.delete();
          m_idle = 0;
        end
      end
    end
  endtask

  function automatic int model_state();
    if (m_lock_left > 0) return 4;
    if (m_locked) return (m_entry.size() > 0) ? 3 : 2;
    return (m_entry.size() > 0) ? 1 : 0;
  endfunction

  // Model update and full output compare once per cycle, away from the active edge.
  initial begin
    @(posedge clock);
    forever begin
      @(negedge clock);
      model_step();
      check_output("state",        int'(state),        model_state());
      check_output("locked",       int'(locked),       int'(m_locked || m_lock_left > 0));
      check_output("lockout",      int'(lockout),      int'(m_lock_left > 0));
      check_output("unlock_pulse", int'(unlock_pulse), int'(m_unlock));
      check_output("fail_pulse",   int'(fail_pulse),   int'(m_fail));
      check_output("digit_count",  int'(digit_count),  m_entry.size());
      check_output("fail_count",   int'(fail_count),   m_fails);
    end
  end

  task automatic apply_stimulus(input int idx);
    @(negedge clock);
    key      = '0;
    key[idx] = 1'b1;
    @(negedge clock);
    key = '0;
  endtask

  task automatic enter_code(input int d0, input int d1, input int d2, input int d3);
    apply_stimulus(d0);
    apply_stimulus(d1);
    apply_stimulus(d2);
    apply_stimulus(d3);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not finish, actual timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    key   = '0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check_output("rst_state",  int'(state), 0);
    check_output("rst_locked", int'(locked), 0);
    reset = 1'b0;

    // Program 2,0,3,1 then unlock with the same code.
    enter_code(2, 0, 3, 1);
    check_output("prog_state",  int'(state), 2);
    check_output("prog_locked", int'(locked), 1);
    check_output("prog_dc",     int'(digit_count), 0);
    enter_code(2, 0, 3, 1);
    check_output("unl_pulse",  int'(unlock_pulse), 1);
    check_output("unl_locked", int'(locked), 0);
    check_output("unl_fc",     int'(fail_count), 0);
    @(negedge clock);
    check_output("unl_pulse_one_cycle", int'(unlock_pulse), 0);

    // Three wrong codes lead to a lockout of exactly LOCK_CYC cycles.
    enter_code(2, 0, 3, 1);
    enter_code(2, 0, 3, 0);
    check_output("fail1_pulse", int'(fail_pulse), 1);
    check_output("fail1_fc",    int'(fail_count), 1);
    enter_code(2, 0, 3, 0);
    check_output("fail2_fc",    int'(fail_count), 2);
    enter_code(2, 0, 3, 0);
    check_output("fail3_pulse", int'(fail_pulse), 1);
    check_output("fail3_state", int'(state), 4);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!lockout) break;
      cnt++;
      key = (i % 2 == 1) ? 4'b0001 : 4'b0000;
      @(negedge clock);
    end
    key = '0;
    check_output("lockout_len",  cnt, LOCK_CYC);
    check_output("post_lo_state", int'(state), 2);
    check_output("post_lo_fc",   int'(fail_count), 0);

    // One wrong attempt, then multi-key and held-key presses.
    enter_code(0, 0, 0, 0);
    check_output("fc_before_rst", int'(fail_count), 1);
    @(negedge clock);
    key = 4'b0101;
    @(negedge clock);
    key = '0;
    @(negedge clock);
    check_output("multikey_dc", int'(digit_count), 0);
    key = 4'b0010;
    repeat (10) @(negedge clock);
    key = '0;
    @(negedge clock);
    check_output("held_dc",    int'(digit_count), 1);
    check_output("held_state", int'(state), 3);
    apply_stimulus(0);
    check_output("two_dc", int'(digit_count), 2);

    // Reset with a key held through it.
    key   = 4'b1000;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check_output("hold_rst_state", int'(state), 0);
    check_output("hold_rst_dc",    int'(digit_count), 0);
    check_output("hold_rst_fc",    int'(fail_count), 0);
    check_output("hold_rst_lock",  int'(locked), 0);
    key = '0;
    apply_stimulus(3);
    check_output("after_rel_dc",    int'(digit_count), 1);
    check_output("after_rel_state", int'(state), 1);
    apply_stimulus(1);
    apply_stimulus(1);
    apply_stimulus(1);
    check_output("reprog_state", int'(state), 2);
    enter_code(3, 1, 1, 1);
    check_output("reprog_unlock", int'(unlock_pulse), 1);

    // Idle partial entry while locked.
    enter_code(0, 1, 2, 3);
    enter_code(1, 1, 1, 1);
    apply_stimulus(0);
    apply_stimulus(1);
    repeat (9) @(negedge clock);
    check_output("idle_mid_state", int'(state), 3);
    repeat (15) @(negedge clock);
`ifdef ENTRY_TIMEOUT_EN
    check_output("timeout_state", int'(state), 2);
    check_output("timeout_dc",    int'(digit_count), 0);
`else
    check_output("no_timeout_state", int'(state), 3);
    check_output("no_timeout_dc",    int'(digit_count), 2);
`endif
    check_output("idle_fc", int'(fail_count), 1);

    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
